instr_encoder: RTL

Sequential RISC-V RV32I instruction encoder: the inverse of the immediate/field decode path in the core's decode stage. Accepts decoded fields (format, opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake, scatters the immediate into its format-specific bit positions, range-checks it, and emits the packed 32-bit word with an auto-incrementing byte address. Used by the boot/test program loader to fill instruction memory, and by the bench as a golden encoder for decode checks.

---
 rtl/instr_encoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into a 32-bit instruction word.
// The immediate is scattered into its format-specific bit positions and
// range-checked. One output register stage sits behind a valid/ready
// handshake. Each word carries an auto-incrementing byte address.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic              load;
  logic              xfer;
  logic              fits_12;
  logic              fits_13;
  logic              fits_21;
  logic [31:0]       enc_word;
  logic              enc_err;
  logic [ADDR_W-1:0] next_addr;

  // Handshake qualifiers; in_ready depends on out_ready only, never on in_valid
  always_comb begin
    in_ready = !out_valid || out_ready;
    load     = in_valid && in_ready;
    xfer     = out_valid && out_ready;
  end

  // Signed-range checks: the value fits in N bits if all bits above N-1 match the sign
  always_comb begin
    fits_12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    fits_13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    fits_21 = (imm[31:20] == '0) || (imm[31:20] == '1);
  end

  // Field placement and error flag per format; invalid formats emit a NOP
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b1;
    case (fmt)
      FMT_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !fits_12;
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !fits_12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !fits_13 || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = (imm[11:0] != '0);
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !fits_21 || imm[0];
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output register stage, address allocation and error counter.
  // The address is assigned when a word is loaded, not when it leaves.
  // That way a clear during a stall leaves the presented address alone and
  // only re-bases the word that follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
      next_addr <= BASE_ADDR;
      err_count <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_word  <= enc_word;
        out_err   <= enc_err;
        out_addr  <= clear ? BASE_ADDR : next_addr;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      if (clear) begin
        next_addr <= load ? (BASE_ADDR + ADDR_STEP) : BASE_ADDR;
      end else if (load) begin
        next_addr <= next_addr + ADDR_STEP;
      end

      if (clear) begin
        err_count <= '0;
      end else if (xfer && out_err && (err_count != '1)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
